alu_exec_cdb_stage: RTL and testbench
=====================================

ALU_EXEC_CDB_STAGE -- requirements
Module: alu_exec_cdb_stage

Interface
REQ-001 SHALL have parameter TAG_W, default 4, meaning ROB tag width (ROB_DEPTH_BITS).
REQ-002 SHALL have parameter BUF_DEPTH, default 2, meaning result buffer entries; only 2 is supported.
REQ-003 SHALL have port clk  in  1  rising-edge clock; the only clock.
REQ-004 SHALL have port rst  in  1  reset, synchronous, active-high.
REQ-005 SHALL have port flush  in  1  branch-mispredict flush.
REQ-006 SHALL have port issue_valid  in  1  reservation station presents a ready op.
REQ-007 SHALL have port issue_alu_ctl  in  4  operation code, per REQ-013.
REQ-008 SHALL have port issue_tag  in  TAG_W  destination ROB tag.
REQ-009 SHALL have port issue_op1 / issue_op2  in  32 each  resolved operands.
REQ-010 SHALL have port issue_stall  out  1  high: reservation station holds its entry (drives e_hc.stall).
REQ-011 SHALL have ports cdb_req  out  1, cdb_tag  out  TAG_W, cdb_value  out  32, cdb_ovf  out  1; together these form the CDB broadcast request (ovf = signed overflow).
REQ-012 SHALL have port cdb_grant  in  1  CDB arbiter accepts the current request this cycle.

Function
REQ-013 SHALL decode alu_ctl as: 0 ADD, 1 ADDU, 2 SUB, 3 SUBU, 4 AND, 5 OR, 6 XOR, 7 NOR, 8 SLT, 9 SLTU, 10 SLL, 11 SRL, 12 SRA, 13 LUI; codes 14-15 yield result 0, ovf 0.
REQ-014 SHALL compute ADD/ADDU/SUB/SUBU modulo 2^32; ovf SHALL be 1 only for ADD/SUB with signed overflow, else 0.
REQ-015 SHALL compute SLT signed and SLTU unsigned, with result 32'd1 or 32'd0.
REQ-016 SHALL shift op2 by op1[4:0] for SLL/SRL/SRA (SRA sign-fills); LUI SHALL produce {op2[15:0],16'h0000}.
REQ-017 SHALL accept an issue when issue_valid & !issue_stall & !flush.
REQ-018 SHALL compute the result combinationally and write {tag,result,ovf} into the result FIFO at the accepting edge; the entry is visible on cdb_* the next cycle (1-cycle latency).
REQ-019 FIFO: 2 entries, in-order; cdb_* SHALL show the head entry; cdb_req = (count != 0).
REQ-020 SHALL pop the head at an edge where cdb_req & cdb_grant.
REQ-021 issue_stall SHALL be (count == 2) & !(cdb_grant & cdb_req), i.e. same-cycle grant frees a slot for a same-cycle issue.
REQ-022 SHALL handle simultaneous push and pop so that count is unchanged and order is preserved; when count == 1, the pushed entry becomes head after the pop.
REQ-023 cdb_tag/cdb_value/cdb_ovf SHALL hold stable while cdb_req = 1 and no grant occurs.
REQ-024 cdb_grant while cdb_req = 0 SHALL be ignored.
REQ-025 Full FIFO plus issue_valid without grant: no accept; the issue stays pending upstream, with no drop or overwrite.
REQ-026 flush SHALL set count to 0 at the next edge, discard any same-cycle issue, and ignore a same-cycle grant; flush has priority over issue and grant.
REQ-027 Read/write pointers SHALL wrap modulo 2; count SHALL never exceed 2 or go below 0 (assertion).

Reset
REQ-028 rst SHALL be sampled only at posedge clk and take priority over flush, issue and grant.
REQ-029 On reset: count = 0, pointers = 0, cdb_req = 0, issue_stall = 0; cdb_tag/value/ovf SHALL read 0.
REQ-030 Reset asserted mid-operation SHALL discard all buffered results with no CDB broadcast in the following cycle.

Verification
REQ-031 ADD op1=32'h7FFFFFFF op2=1 tag=3, grant held high -> next cycle cdb_req=1, tag=3, value=32'h80000000, ovf=1; ADDU with the same operands gives ovf=0.
REQ-032 SRA op1=4 op2=32'h80000010 -> value 32'hF8000001; SLTU op1=1 op2=32'hFFFFFFFF -> 1; SLT with the same operands -> 0.
REQ-033 Grant low, three back-to-back issues (tags 1,2,3) -> tags 1,2 accepted; issue_stall=1 on the third; raising grant pops tag 1 and accepts tag 3 in the same cycle; output order is 1,2,3.
REQ-034 count=2 with flush and issue_valid and grant all high -> next cycle cdb_req=0, issue_stall=0, and no further broadcasts.
REQ-035 Grant low for 5 cycles with entry tag=7 -> cdb_* stable throughout; grant pulse -> entry popped exactly once.
REQ-036 rst high with count=2 -> next cycle cdb_req=0, outputs 0; issue after rst deasserts -> normal 1-cycle latency.

Source files
------------

// File: rtl/alu_exec_cdb_stage.sv
// Integer ALU execute stage feeding a 2-entry result buffer that requests the CDB.
// Latency: 1 cycle from accepted issue to cdb_req; head entry broadcasts until granted.
// Backpressure: issue_stall when the buffer is full and not being granted this cycle.

module result_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 2
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           clr,
  input  logic                           push_vld,
  input  logic [W-1:0]                   push_dat,
  input  logic                           pop_vld,
  output logic [W-1:0]                   head_dat,
  output logic [$clog2(DEPTH+1)-1:0]     count
);
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH+1);

  logic [W-1:0]     mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;

  function automatic logic [PTR_W-1:0] nxt(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH-1)) ? '0 : p + PTR_W'(1);
  endfunction

  always_ff @(posedge clk) begin
    if (push_vld) mem[wr_ptr] <= push_dat;
  end

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_vld) wr_ptr <= nxt(wr_ptr);
      if (pop_vld)  rd_ptr <= nxt(rd_ptr);
      case ({push_vld, pop_vld})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  assign head_dat = mem[rd_ptr];

  a_count_range: assert property (@(posedge clk) disable iff (rst) count <= CNT_W'(DEPTH));
  a_no_underflow: assert property (@(posedge clk) disable iff (rst || clr) pop_vld |-> count != '0);
endmodule

module alu_exec_cdb_stage #(
  parameter int TAG_W     = 4,
  parameter int BUF_DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             issue_valid,
  input  logic [3:0]       issue_alu_ctl,
  input  logic [TAG_W-1:0] issue_tag,
  input  logic [31:0]      issue_op1,
  input  logic [31:0]      issue_op2,
  output logic             issue_stall,
  output logic             cdb_req,
  output logic [TAG_W-1:0] cdb_tag,
  output logic [31:0]      cdb_value,
  output logic             cdb_ovf,
  input  logic             cdb_grant
);
  localparam int CNT_W = $clog2(BUF_DEPTH+1);

  typedef enum logic [3:0] {
    OP_ADD  = 4'd0,  OP_ADDU = 4'd1,  OP_SUB = 4'd2,  OP_SUBU = 4'd3,
    OP_AND  = 4'd4,  OP_OR   = 4'd5,  OP_XOR = 4'd6,  OP_NOR  = 4'd7,
    OP_SLT  = 4'd8,  OP_SLTU = 4'd9,  OP_SLL = 4'd10, OP_SRL  = 4'd11,
    OP_SRA  = 4'd12, OP_LUI  = 4'd13
  } alu_op_e;

  typedef struct packed {
    logic [TAG_W-1:0] tag;
    logic [31:0]      value;
    logic             ovf;
  } res_t;

  logic [31:0]      sum, diff, alu_res;
  logic             alu_ovf;
  logic [4:0]       shamt;
  res_t             push_dat, head_dat;
  logic [CNT_W-1:0] count;
  logic             push_vld, pop_vld;

  assign sum   = issue_op1 + issue_op2;
  assign diff  = issue_op1 - issue_op2;
  assign shamt = issue_op1[4:0];

  always_comb begin
    alu_res = '0;
    alu_ovf = 1'b0;
    case (alu_op_e'(issue_alu_ctl))
      OP_ADD: begin
        alu_res = sum;
        alu_ovf = (issue_op1[31] == issue_op2[31]) && (sum[31] != issue_op1[31]);
      end
      OP_ADDU: alu_res = sum;
      OP_SUB: begin
        alu_res = diff;
        alu_ovf = (issue_op1[31] != issue_op2[31]) && (diff[31] != issue_op1[31]);
      end
      OP_SUBU: alu_res = diff;
      OP_AND:  alu_res = issue_op1 & issue_op2;
      OP_OR:   alu_res = issue_op1 | issue_op2;
      OP_XOR:  alu_res = issue_op1 ^ issue_op2;
      OP_NOR:  alu_res = ~(issue_op1 | issue_op2);
      OP_SLT:  alu_res = {31'd0, $signed(issue_op1) < $signed(issue_op2)};
      OP_SLTU: alu_res = {31'd0, issue_op1 < issue_op2};
      OP_SLL:  alu_res = issue_op2 << shamt;
      OP_SRL:  alu_res = issue_op2 >> shamt;
      OP_SRA:  alu_res = $signed(issue_op2) >>> shamt;
      OP_LUI:  alu_res = {issue_op2[15:0], 16'h0000};
      default: begin
        alu_res = '0;
        alu_ovf = 1'b0;
      end
    endcase
  end

  // A grant in the same cycle frees the slot the new issue lands in.
  assign cdb_req     = (count != '0);
  assign issue_stall = (count == CNT_W'(BUF_DEPTH)) && !(cdb_grant && cdb_req);
  assign push_vld    = issue_valid && !issue_stall && !flush;
  assign pop_vld     = cdb_req && cdb_grant && !flush;

  assign push_dat = '{tag: issue_tag, value: alu_res, ovf: alu_ovf};

  result_fifo #(.W($bits(res_t)), .DEPTH(BUF_DEPTH)) u_res_fifo (
    .clk      (clk),
    .rst      (rst),
    .clr      (flush),
    .push_vld (push_vld),
    .push_dat (push_dat),
    .pop_vld  (pop_vld),
    .head_dat (head_dat),
    .count    (count)
  );

  // Stale buffer contents never leak onto the bus when nothing is requested.
  assign cdb_tag   = cdb_req ? head_dat.tag   : '0;
  assign cdb_value = cdb_req ? head_dat.value : '0;
  assign cdb_ovf   = cdb_req ? head_dat.ovf   : 1'b0;
endmodule

// File: tb/tb_alu_exec_cdb_stage.sv
// Directed bench for alu_exec_cdb_stage with a queue-based reference model
// checked against the DUT every cycle, plus literal expectations.
module tb_alu_exec_cdb_stage;
  localparam int TAG_W = 4;
  localparam longint MAXI = 64'sd2147483647;
  localparam longint MINI = -MAXI - 64'sd1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             rst, flush, issue_valid, issue_stall, cdb_req, cdb_ovf, cdb_grant;
  logic [3:0]       issue_alu_ctl;
  logic [TAG_W-1:0] issue_tag, cdb_tag;
  logic [31:0]      issue_op1, issue_op2, cdb_value;

  int n_cmp = 0;
  int n_bad = 0;
  bit chk_en = 1'b0;
  int n_pop;

  typedef struct {
    logic [TAG_W-1:0] tag;
    logic [31:0]      value;
    logic             ovf;
  } ent_t;

  ent_t             mq[$];
  logic [TAG_W-1:0] pop_log[$];

  alu_exec_cdb_stage #(.TAG_W(TAG_W), .BUF_DEPTH(2)) dut (
    .clk           (clk),
    .rst           (rst),
    .flush         (flush),
    .issue_valid   (issue_valid),
    .issue_alu_ctl (issue_alu_ctl),
    .issue_tag     (issue_tag),
    .issue_op1     (issue_op1),
    .issue_op2     (issue_op2),
    .issue_stall   (issue_stall),
    .cdb_req       (cdb_req),
    .cdb_tag       (cdb_tag),
    .cdb_value     (cdb_value),
    .cdb_ovf       (cdb_ovf),
    .cdb_grant     (cdb_grant)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic ent_t ref_alu(input logic [3:0] ctl, input logic [TAG_W-1:0] tag,
                                   input logic [31:0] a, input logic [31:0] b);
    ent_t   e;
    longint sa, sb, r;
    int     s;
    e.tag   = tag;
    e.value = 32'h0;
    e.ovf   = 1'b0;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    s  = int'(a[4:0]);
    r  = 0;
    case (ctl)
      4'd0:  begin r = sa + sb; e.value = r[31:0]; e.ovf = (r > MAXI) || (r < MINI); end
      4'd1:  e.value = a + b;
      4'd2:  begin r = sa - sb; e.value = r[31:0]; e.ovf = (r > MAXI) || (r < MINI); end
      4'd3:  e.value = a - b;
      4'd4:  e.value = a & b;
      4'd5:  e.value = a | b;
      4'd6:  e.value = a ^ b;
      4'd7:  e.value = ~(a | b);
      4'd8:  e.value = (sa < sb) ? 32'd1 : 32'd0;
      4'd9:  e.value = (a < b) ? 32'd1 : 32'd0;
      4'd10: e.value = b << s;
      4'd11: e.value = b >> s;
      4'd12: e.value = (b >> s) | (b[31] ? ~(32'hFFFFFFFF >> s) : 32'h0);
      4'd13: e.value = {b[15:0], 16'h0000};
      default: e.value = 32'h0;
    endcase
    return e;
  endfunction

  // Reference model: ordered queue of pending results, advanced at each edge.
  always @(posedge clk) begin
    bit   acc;
    ent_t e;
    if (rst) begin
      mq.delete();
      chk_en = 1'b1;
    end else if (flush) begin
      mq.delete();
    end else begin
      acc = issue_valid && !(mq.size() == 2 && !(cdb_grant && mq.size() != 0));
      e   = ref_alu(issue_alu_ctl, issue_tag, issue_op1, issue_op2);
      if (cdb_grant && mq.size() != 0) begin
        pop_log.push_back(mq[0].tag);
        void'(mq.pop_front());
      end
      if (acc) mq.push_back(e);
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("m_req", 32'(cdb_req), 32'(mq.size() != 0));
      chk("m_stall", 32'(issue_stall), 32'(mq.size() == 2 && !cdb_grant));
      if (mq.size() != 0) begin
        chk("m_tag", 32'(cdb_tag), 32'(mq[0].tag));
        chk("m_value", cdb_value, mq[0].value);
        chk("m_ovf", 32'(cdb_ovf), 32'(mq[0].ovf));
      end
    end
  end

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic look();
    @(negedge clk);
  endtask

  task automatic drive(input logic [3:0] c, input logic [TAG_W-1:0] t,
                       input logic [31:0] a, input logic [31:0] b);
    issue_valid   = 1'b1;
    issue_alu_ctl = c;
    issue_tag     = t;
    issue_op1     = a;
    issue_op2     = b;
  endtask

  task automatic one_op(input string nm, input logic [3:0] c, input logic [TAG_W-1:0] t,
                        input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp_v, input logic exp_o);
    cycle();
    drive(c, t, a, b);
    cycle();
    issue_valid = 1'b0;
    look();
    chk({nm, "_req"}, 32'(cdb_req), 32'd1);
    chk({nm, "_tag"}, 32'(cdb_tag), 32'(t));
    chk({nm, "_value"}, cdb_value, exp_v);
    chk({nm, "_ovf"}, 32'(cdb_ovf), 32'(exp_o));
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; issue_valid = 1'b0; issue_alu_ctl = '0;
    issue_tag = '0; issue_op1 = '0; issue_op2 = '0; cdb_grant = 1'b0;
    cycle();
    cycle();
    rst = 1'b0;
    look();
    chk("rst_req", 32'(cdb_req), 32'd0);
    chk("rst_stall", 32'(issue_stall), 32'd0);
    chk("rst_tag", 32'(cdb_tag), 32'd0);
    chk("rst_value", cdb_value, 32'd0);
    chk("rst_ovf", 32'(cdb_ovf), 32'd0);

    // Single ops with grant held high.
    cycle();
    cdb_grant = 1'b1;
    one_op("add_ovf", 4'd0, 4'd3, 32'h7FFFFFFF, 32'h1, 32'h80000000, 1'b1);
    one_op("addu", 4'd1, 4'd4, 32'h7FFFFFFF, 32'h1, 32'h80000000, 1'b0);
    one_op("sub_ovf", 4'd2, 4'd5, 32'h80000000, 32'h1, 32'h7FFFFFFF, 1'b1);
    one_op("sra", 4'd12, 4'd6, 32'd4, 32'h80000010, 32'hF8000001, 1'b0);
    one_op("sltu", 4'd9, 4'd7, 32'd1, 32'hFFFFFFFF, 32'd1, 1'b0);
    one_op("slt", 4'd8, 4'd8, 32'd1, 32'hFFFFFFFF, 32'd0, 1'b0);
    one_op("lui", 4'd13, 4'd9, 32'd0, 32'h1234ABCD, 32'hABCD0000, 1'b0);
    one_op("sll", 4'd10, 4'd10, 32'd8, 32'h00FF00FF, 32'hFF00FF00, 1'b0);
    one_op("nor", 4'd7, 4'd11, 32'hF0F0F0F0, 32'h0F0F0000, 32'h00000F0F, 1'b0);
    one_op("code14", 4'd14, 4'd12, 32'd5, 32'd6, 32'd0, 1'b0);

    // Fill with grant low, then a same-cycle grant admits the stalled issue.
    cycle();
    cdb_grant = 1'b0;
    pop_log.delete();
    drive(4'd1, 4'd1, 32'd1, 32'd1);
    cycle();
    issue_tag = 4'd2;
    cycle();
    issue_tag = 4'd3;
    look();
    chk("full_stall", 32'(issue_stall), 32'd1);
    chk("full_head", 32'(cdb_tag), 32'd1);
    cycle();
    cdb_grant = 1'b1;
    look();
    chk("grant_unstall", 32'(issue_stall), 32'd0);
    cycle();
    issue_valid = 1'b0;
    look();
    chk("after_pop_head", 32'(cdb_tag), 32'd2);
    cycle();
    cycle();
    cdb_grant = 1'b0;
    look();
    chk("drained_req", 32'(cdb_req), 32'd0);
    chk("order_n", 32'(pop_log.size()), 32'd3);
    if (pop_log.size() == 3) begin
      chk("order_0", 32'(pop_log[0]), 32'd1);
      chk("order_1", 32'(pop_log[1]), 32'd2);
      chk("order_2", 32'(pop_log[2]), 32'd3);
    end

    // Flush with issue and grant asserted on a full buffer.
    cycle();
    drive(4'd1, 4'd4, 32'd2, 32'd3);
    cycle();
    issue_tag = 4'd5;
    cycle();
    n_pop = pop_log.size();
    flush = 1'b1;
    issue_tag = 4'd6;
    cdb_grant = 1'b1;
    cycle();
    flush = 1'b0;
    issue_valid = 1'b0;
    look();
    chk("flush_req", 32'(cdb_req), 32'd0);
    chk("flush_stall", 32'(issue_stall), 32'd0);
    cycle();
    cycle();
    look();
    chk("flush_no_bcast", 32'(pop_log.size()), 32'(n_pop));
    chk("flush_req_late", 32'(cdb_req), 32'd0);

    // Held entry stays stable until a single grant pulse.
    cycle();
    cdb_grant = 1'b0;
    drive(4'd0, 4'd7, 32'd10, 32'd20);
    cycle();
    issue_valid = 1'b0;
    n_pop = pop_log.size();
    for (int i = 0; i < 5; i++) begin
      look();
      chk("hold_req", 32'(cdb_req), 32'd1);
      chk("hold_tag", 32'(cdb_tag), 32'd7);
      chk("hold_value", cdb_value, 32'd30);
      cycle();
    end
    cdb_grant = 1'b1;
    cycle();
    cdb_grant = 1'b0;
    look();
    chk("pulse_req", 32'(cdb_req), 32'd0);
    chk("pulse_once", 32'(pop_log.size()), 32'(n_pop + 1));

    // Reset while full, then normal operation.
    cycle();
    drive(4'd1, 4'd1, 32'd1, 32'd2);
    cycle();
    issue_tag = 4'd2;
    cycle();
    rst = 1'b1;
    issue_tag = 4'd8;
    cycle();
    rst = 1'b0;
    issue_valid = 1'b0;
    look();
    chk("rst2_req", 32'(cdb_req), 32'd0);
    chk("rst2_stall", 32'(issue_stall), 32'd0);
    chk("rst2_tag", 32'(cdb_tag), 32'd0);
    chk("rst2_value", cdb_value, 32'd0);
    chk("rst2_ovf", 32'(cdb_ovf), 32'd0);
    one_op("post_rst_or", 4'd5, 4'd9, 32'h000000F0, 32'h0000000F, 32'h000000FF, 1'b0);
    cycle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
